// File: rtl/preproc_pkg.sv
// Shared constants and FSM state encoding for the FFT/IFFT front-end preprocessor.
// FFT length and cyclic-prefix base lengths are given for the 2048-point case.
package preproc_pkg;

    localparam int FFT_MAX_NUM    = 2048;
    localparam int FFT_NUM_NBIT   = 12;
    localparam int CP_NOR_FST_NUM = 160;
    localparam int CP_NOR_NUM     = 144;
    localparam int CP_EXT_NUM     = 512;

    typedef enum logic [1:0] {
        PP_ST_IDLE = 2'd0,
        PP_ST_SKIP = 2'd1,
        PP_ST_SYM  = 2'd2
    } pp_state_e;

endpackage

// File: rtl/preproc_cplen.sv
// Combinational symbol length N and cyclic-prefix length for one symbol configuration.
module preproc_cplen
    import preproc_pkg::*;
(
    input  logic                    fft_type_i,
    input  logic                    cp_type_i,
    input  logic                    din_s_i,
    input  logic [1:0]              num_pat_i,
    output logic [FFT_NUM_NBIT-1:0] cp_len_o,
    output logic [FFT_NUM_NBIT-1:0] sym_len_o
);

    logic [13:0] base;
    logic [13:0] scaled;

    always_comb begin
        base   = cp_type_i ? 14'(CP_EXT_NUM) : (din_s_i ? 14'(CP_NOR_FST_NUM) : 14'(CP_NOR_NUM));
        // CP shrinks with the FFT size in quarters: base * (4 - num_pat) / 4.
        scaled = base * (14'd4 - {12'd0, num_pat_i});
        cp_len_o  = fft_type_i ? '0 : scaled[13:2];
        sym_len_o = FFT_NUM_NBIT'(FFT_MAX_NUM) - {1'b0, num_pat_i, 9'd0};
    end

endmodule

// File: rtl/preproc.sv
// Front-end ahead of the FFT/IFFT core: drops the cyclic prefix (FFT only) and frames
// the N symbol samples with sop/eop, one registered stage from din_v to dout_valid.
module preproc
    import preproc_pkg::*;
#(
    parameter int DATA_NBIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fft_type,
    input  logic                 cp_type,
    input  logic [1:0]           num_pat,
    input  logic                 din_h,
    input  logic                 din_s,
    input  logic                 din_v,
    input  logic [DATA_NBIT-1:0] din_i,
    input  logic [DATA_NBIT-1:0] din_q,
    input  logic                 dout_rdy,
    output logic                 dout_sop,
    output logic                 dout_eop,
    output logic                 dout_valid,
    output logic [DATA_NBIT-1:0] dout_real,
    output logic [DATA_NBIT-1:0] dout_imag,
    output logic                 dout_fst_cp,
    output logic                 sync_err,
    output logic                 ovf_err,
    output logic [1:0]           dbg_state_o
);

    pp_state_e state_q, state_d;
    logic [FFT_NUM_NBIT-1:0] cnt_q, cnt_d;
    logic ft_q, ft_d, ct_q, ct_d, s_q, s_d;
    logic [1:0] np_q, np_d;
    logic sync_q, sync_d, ovf_q, ovf_d;
    logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [DATA_NBIT-1:0] real_q, real_d, imag_q, imag_d;

    logic start;
    logic [FFT_NUM_NBIT-1:0] cp_len, sym_len;

    assign start = din_v & din_h;

    // A new header uses the live configuration; otherwise the one latched at its header.
    preproc_cplen u_cplen (
        .fft_type_i (start ? fft_type : ft_q),
        .cp_type_i  (start ? cp_type  : ct_q),
        .din_s_i    (start ? din_s    : s_q),
        .num_pat_i  (start ? num_pat  : np_q),
        .cp_len_o   (cp_len),
        .sym_len_o  (sym_len)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ft_d    = ft_q;
        ct_d    = ct_q;
        s_d     = s_q;
        np_d    = np_q;
        sync_d  = sync_q;
        ovf_d   = ovf_q | (valid_q & ~dout_rdy);
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        if (start) begin
            ft_d  = fft_type;
            ct_d  = cp_type;
            s_d   = din_s;
            np_d  = num_pat;
            cnt_d = FFT_NUM_NBIT'(1);
            if (state_q != PP_ST_IDLE) sync_d = 1'b1;
            if (cp_len != '0) begin
                state_d = PP_ST_SKIP;
            end else begin
                state_d = PP_ST_SYM;
                valid_d = 1'b1;
                sop_d   = 1'b1;
            end
        end else if (din_v) begin
            case (state_q)
                PP_ST_SKIP: begin
                    if (cnt_q == cp_len - FFT_NUM_NBIT'(1)) begin
                        state_d = PP_ST_SYM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + FFT_NUM_NBIT'(1);
                    end
                end
                PP_ST_SYM: begin
                    valid_d = 1'b1;
                    sop_d   = (cnt_q == '0);
                    if (cnt_q == sym_len - FFT_NUM_NBIT'(1)) begin
                        eop_d   = 1'b1;
                        state_d = PP_ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + FFT_NUM_NBIT'(1);
                    end
                end
                default: ;
            endcase
        end
        real_d = valid_d ? din_i : '0;
        imag_d = valid_d ? din_q : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PP_ST_IDLE;
            cnt_q   <= '0;
            ft_q    <= 1'b0;
            ct_q    <= 1'b0;
            s_q     <= 1'b0;
            np_q    <= 2'd0;
            sync_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            real_q  <= '0;
            imag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ft_q    <= ft_d;
            ct_q    <= ct_d;
            s_q     <= s_d;
            np_q    <= np_d;
            sync_q  <= sync_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            real_q  <= real_d;
            imag_q  <= imag_d;
        end
    end

    assign dout_valid  = valid_q;
    assign dout_sop    = sop_q;
    assign dout_eop    = eop_q;
    assign dout_real   = real_q;
    assign dout_imag   = imag_q;
    assign dout_fst_cp = s_q;
    assign sync_err    = sync_q;
    assign ovf_err     = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_preproc.sv
// Randomised-data bench for preproc: a sample-index reference model predicts every
// forwarded sample, and each scenario task compares the captured stream inline.
module tb_preproc;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fft_type = 1'b0, cp_type = 1'b0, din_h = 1'b0, din_s = 1'b0, din_v = 1'b0;
    logic [1:0] num_pat = 2'd0;
    logic [W-1:0] din_i = '0, din_q = '0;
    logic dout_rdy = 1'b1;
    logic dout_sop, dout_eop, dout_valid, dout_fst_cp, sync_err, ovf_err;
    logic [W-1:0] dout_real, dout_imag;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    preproc #(.DATA_NBIT(W)) dut (
        .clk(clk), .reset(reset), .fft_type(fft_type), .cp_type(cp_type), .num_pat(num_pat),
        .din_h(din_h), .din_s(din_s), .din_v(din_v), .din_i(din_i), .din_q(din_q),
        .dout_rdy(dout_rdy), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_valid(dout_valid),
        .dout_real(dout_real), .dout_imag(dout_imag), .dout_fst_cp(dout_fst_cp),
        .sync_err(sync_err), .ovf_err(ovf_err), .dbg_state_o(dbg_state)
    );

    // ---------------- capture ----------------
    int unsigned cyc = 0;
    logic [2*W+2:0] exp_q[$];
    logic [2*W+2:0] obs_q[$];
    int unsigned obs_cyc[$];
    int zero_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (dout_valid) begin
                obs_q.push_back({dout_sop, dout_eop, dout_fst_cp, dout_real, dout_imag});
                obs_cyc.push_back(cyc);
            end else if (dout_sop || dout_eop || dout_real != '0 || dout_imag != '0) begin
                zero_viol++;
            end
        end
    end

    // ---------------- reference model ----------------
    int m_idx = -1;
    int m_cp = 0;
    int m_n = 0;
    bit m_fst = 1'b0;
    bit exp_sync = 1'b0;
    bit exp_ovf = 1'b0;

    task automatic model(input bit h, input bit s, input bit ft, input bit ct, input int np,
                         input logic [W-1:0] i, input logic [W-1:0] q);
        int base;
        if (h) begin
            if (m_idx >= 0) exp_sync = 1'b1;
            m_n   = 2048 - 512 * np;
            base  = ct ? 512 : (s ? 160 : 144);
            m_cp  = ft ? 0 : (base * (4 - np)) / 4;
            m_fst = s;
            m_idx = 0;
        end
        if (m_idx < 0) return;
        if (m_idx >= m_cp)
            exp_q.push_back({m_idx == m_cp, m_idx == m_cp + m_n - 1, m_fst, i, q});
        m_idx++;
        if (m_idx == m_cp + m_n) m_idx = -1;
    endtask

    // Called at a negedge; returns at a negedge, gap clocks later.
    task automatic drive(input bit h, input bit s, input bit ft, input bit ct, input int np,
                         input int gap);
        logic [W-1:0] i, q;
        i = W'($urandom);
        q = W'($urandom);
        din_v = 1'b1; din_h = h; din_s = s; fft_type = ft; cp_type = ct;
        num_pat = 2'(np); din_i = i; din_q = q;
        model(h, s, ft, ct, np, i, q);
        @(negedge clk);
        din_v = 1'b0; din_h = 1'b0; din_s = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send(input bit s, input bit ft, input bit ct, input int np, input int n, input int gap);
        for (int k = 0; k < n; k++) drive(k == 0, s, ft, ct, np, gap);
    endtask

    task automatic clear_streams();
        repeat (3) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dout_sop, dout_eop, dout_valid, dout_real, dout_imag, dout_fst_cp, sync_err, ovf_err, dbg_state} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b re=%h im=%h fst=%b serr=%b oerr=%b st=%0d want all 0",
                     dout_valid, dout_sop, dout_eop, dout_real, dout_imag, dout_fst_cp, sync_err, ovf_err, dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fft_normal();
        send(1'b1, 1'b0, 1'b0, 0, 2208, 5);
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 5); // stray valids in IDLE
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 2048 || exp_q.size() != 2048) begin
            n_errors++; $display("FAIL t1_count: got %0d want 2048", obs_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t1_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (obs_q.size() > 0 && obs_q[0][2*W+2:2*W] !== 3'b101) begin
            n_errors++; $display("FAIL t1_sop_fst: got %b want 101", obs_q[0][2*W+2:2*W]);
        end
        n_checks++;
        if (sync_err !== exp_sync || ovf_err !== exp_ovf) begin
            n_errors++; $display("FAIL t1_errs: got %b%b want %b%b", sync_err, ovf_err, exp_sync, exp_ovf);
        end
        clear_streams();
    endtask

    task automatic test_fft_ext_then_normal();
        send(1'b1, 1'b0, 1'b1, 3, 640, 5);
        send(1'b0, 1'b0, 1'b0, 1, 1644, 5);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 512 + 1536) begin
            n_errors++; $display("FAIL t2_count: got %0d want 2048", obs_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t2_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        clear_streams();
    endtask

    task automatic test_ifft();
        send(1'b0, 1'b1, 1'b0, 2, 1024, 5);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1024) begin
            n_errors++; $display("FAIL t3_count: got %0d want 1024", obs_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t3_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        clear_streams();
    endtask

    task automatic test_sync_abort();
        int eops;
        send(1'b0, 1'b0, 1'b0, 0, 144 + 700, 5);
        send(1'b1, 1'b0, 1'b0, 0, 2208, 5);
        repeat (3) @(negedge clk);
        eops = 0;
        foreach (obs_q[k]) eops += int'(obs_q[k][2*W+1]);
        n_checks++;
        if (obs_q.size() != 700 + 2048 || eops != 1) begin
            n_errors++; $display("FAIL t4_count: got %0d/%0d eop want 2748/1", obs_q.size(), eops);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t4_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (sync_err !== 1'b1) begin
            n_errors++; $display("FAIL t4_sync_err: got %b want 1", sync_err);
        end
        clear_streams();
    endtask

    task automatic test_ovf_and_reset();
        send(1'b0, 1'b0, 1'b0, 3, 36 + 100, 5);
        dout_rdy = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3, 5);
        dout_rdy = 1'b1;
        exp_ovf = 1'b1;
        for (int k = 0; k < 50; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 3, 5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3, 1);
        #2;
        n_checks++;
        if (ovf_err !== exp_ovf || dout_valid !== 1'b1) begin
            n_errors++; $display("FAIL t5_ovf_sticky: got ovf=%b valid=%b want 1/1", ovf_err, dout_valid);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 152) begin
            n_errors++; $display("FAIL t5_count: got %0d want 152", obs_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t5_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({dout_sop, dout_eop, dout_valid, dout_real, dout_imag, dout_fst_cp, sync_err, ovf_err} !== '0) begin
            n_errors++; $display("FAIL t5_async_reset: got valid=%b ovf=%b re=%h want all 0", dout_valid, ovf_err, dout_real);
        end
        m_idx = -1; exp_sync = 1'b0; exp_ovf = 1'b0;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(1'b1, 1'b0, 1'b1, 3, 640, 5);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 512 || sync_err !== 1'b0 || ovf_err !== 1'b0) begin
            n_errors++; $display("FAIL t5_restart: got %0d serr=%b oerr=%b want 512/0/0", obs_q.size(), sync_err, ovf_err);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t5r_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        clear_streams();
    endtask

    task automatic test_back_to_back();
        int unsigned first_cyc;
        first_cyc = cyc;
        for (int s = 0; s < 3; s++) send(1'($urandom_range(0, 1)), 1'b1, 1'b0, 3, 512, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1536) begin
            n_errors++; $display("FAIL t6_count: got %0d want 1536", obs_q.size());
        end
        n_checks++;
        if (obs_cyc.size() > 0 && obs_cyc[0] != first_cyc + 1) begin
            n_errors++; $display("FAIL t6_latency: got cycle %0d want %0d", obs_cyc[0], first_cyc + 1);
        end
        for (int k = 1; k < obs_cyc.size(); k++) begin
            n_checks++;
            if (obs_cyc[k] != obs_cyc[k-1] + 1) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t6_gap%0d: got cycle %0d want %0d", k, obs_cyc[k], obs_cyc[k-1] + 1);
            end
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_errors++;
                if (n_errors < 20) $display("FAIL t6_sample%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (zero_viol != 0 || sync_err !== exp_sync || ovf_err !== exp_ovf) begin
            n_errors++; $display("FAIL t6_idle_zero_errs: got viol=%0d serr=%b oerr=%b want 0/%b/%b",
                                 zero_viol, sync_err, ovf_err, exp_sync, exp_ovf);
        end
        clear_streams();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fft_normal();
        test_fft_ext_then_normal();
        test_ifft();
        test_sync_abort();
        test_ovf_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
